load_store_unit: RTL and testbench

//  Multi-cycle bridge between the processor's execute stage and the data memory bus. Takes the ALU

---
 rtl/load_store_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Multi-cycle bridge between the execute stage and a req/ack word-wide data bus.
// It accepts one load or store at a time and checks the access width and alignment.
// It then drives the bus until mem_ack arrives, and returns sign- or zero-extended
// load data for writeback. While it works it holds the pipeline with 'stall'.
// Misaligned accesses, illegal widths and accesses that time out end with a
// one-cycle fault pulse instead of a completion pulse.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   req_*            load/store request from execute (held while stall=1)
//   stall            hold PC/pipeline
//   rdata            extended load data (0 for stores/faults), held between pulses
//   rdata_valid      one-cycle completion pulse
//   fault/fault_code one-cycle abort pulse: 01 misaligned, 10 illegal funct3, 11 timeout
//   mem_*            word bus: request held until the single-cycle mem_ack

module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    // Fault code for a request. An illegal funct3 takes priority over misalignment.
    function automatic logic [1:0] check_code(input logic wr, input logic [2:0] f3,
                                              input logic [1:0] a);
        logic [1:0] code;
        code = 2'b00;
        case (f3)
            3'b000:  code = 2'b00;
            3'b001:  code = a[0] ? 2'b01 : 2'b00;
            3'b010:  code = (a != 2'b00) ? 2'b01 : 2'b00;
            3'b100:  code = wr ? 2'b10 : 2'b00;
            3'b101:  code = wr ? 2'b10 : (a[0] ? 2'b01 : 2'b00);
            default: code = 2'b10;
        endcase
        return code;
    endfunction

    // Byte lanes touched by the access. This is the same for loads and stores.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated into every lane, so byte enables alone select the target.
    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        w = d;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] res;
        lane = word >> {off, 3'b000};
        res  = lane;
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b100:  res = {24'h000000, lane[7:0]};
            3'b101:  res = {16'h0000, lane[15:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    logic [1:0]  state_r;
    logic [7:0]  count_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r;
    logic        fault_r;
    logic [1:0]  fault_code_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic [1:0]  req_code_s;
    logic        stall_s;

    // Legality check of the request currently presented
    always_comb begin
        req_code_s = check_code(req_write, req_funct3, req_addr[1:0]);
    end

    // Stall must follow req_valid in the same IDLE cycle, so it is decoded
    // combinationally. It is forced low while reset is asserted.
    always_comb begin
        stall_s = 1'b0;
        if (!reset) begin
            stall_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            stall_s = req_valid;
        end else if (state_r == ST_REQ) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Access FSM, bus registers, timeout counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            count_r       <= 8'd0;
            funct3_r      <= 3'b000;
            offset_r      <= 2'b00;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_code_r  <= 2'b00;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_be_r      <= 4'b0000;
        end else begin
            rdata_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_code_r  <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_code_s != 2'b00) begin
                            fault_r      <= 1'b1;
                            fault_code_r <= req_code_s;
                            rdata_r      <= 32'h0000_0000;
                            state_r      <= ST_ERR;
                        end else begin
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_write;
                            mem_addr_r  <= {req_addr[31:2], 2'b00};
                            mem_be_r    <= byte_enable(req_funct3, req_addr[1:0]);
                            mem_wdata_r <= replicate(req_funct3, req_wdata);
                            funct3_r    <= req_funct3;
                            offset_r    <= req_addr[1:0];
                            count_r     <= 8'd1;
                            state_r     <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An ack wins over a timeout that expires in the same cycle.
                    if (mem_ack) begin
                        mem_req_r     <= 1'b0;
                        rdata_valid_r <= 1'b1;
                        rdata_r       <= mem_we_r ? 32'h0000_0000
                                                  : extend(funct3_r, offset_r, mem_rdata);
                        state_r       <= ST_DONE;
                    end else if (count_r >= TIMEOUT_LIMIT) begin
                        mem_req_r    <= 1'b0;
                        fault_r      <= 1'b1;
                        fault_code_r <= 2'b11;
                        rdata_r      <= 32'h0000_0000;
                        state_r      <= ST_ERR;
                    end else begin
                        count_r <= count_r + 8'd1;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign stall       = stall_s;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign fault       = fault_r;
    assign fault_code  = fault_code_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_be      = mem_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. The stimulus pushes a hand-computed response into
// a queue for each request. A monitor pops from that queue on every rdata_valid/fault
// pulse and compares. The stimulus also checks bus fields, stall and cycle timing.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct packed {
        logic        is_fault;
        logic [1:0]  code;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .fault(fault), .fault_code(fault_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rdata_valid || fault) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_response: got valid=%b fault=%b rdata=%h, required none",
                         rdata_valid, fault, rdata);
            end else begin
                e = exp_q.pop_front();
                chk("resp_fault", {31'd0, fault}, {31'd0, e.is_fault});
                chk("resp_valid", {31'd0, rdata_valid}, {31'd0, !e.is_fault});
                if (e.is_fault) chk("resp_code", {30'd0, fault_code}, {30'd0, e.code});
                chk("resp_rdata", rdata, e.rdata);
            end
        end
    end

    // Legal access. The ack arrives in cycle ack_cycle, counted from cycle 0 (the request).
    task automatic access(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_cycle, input logic [31:0] word, input bit drop_early,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
        exp_q.push_back('{1'b0, 2'b00, exp_rdata});
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        chk({name, "_stall_c0"}, {31'd0, stall}, 32'd1);
        chk({name, "_req_c0"}, {31'd0, mem_req}, 32'd0);
        for (int c = 1; c <= ack_cycle; c++) begin
            @(posedge clk); #1;
            if (drop_early) req_valid = 1'b0;
            mem_ack = (c == ack_cycle);
            mem_rdata = (c == ack_cycle) ? word : 32'h5A5A_5A5A;
            @(negedge clk);
            if (c == 1) begin
                chk({name, "_addr"}, mem_addr, exp_addr);
                chk({name, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
                chk({name, "_we"}, {31'd0, mem_we}, {31'd0, wr});
                if (wr) chk({name, "_wdata"}, mem_wdata, exp_wdata);
            end
            chk({name, "_req_hold"}, {30'd0, mem_req, stall}, 32'd3);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_done"}, {29'd0, rdata_valid, stall, mem_req}, 32'd4);
    endtask

    // Illegal access: fault one cycle later, no bus request
    task automatic illegal(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] code);
        exp_q.push_back('{1'b1, code, 32'h0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr;
        req_wdata = 32'h1234_5678;
        @(negedge clk);
        chk({name, "_stall_c0"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_err"}, {29'd0, fault, stall, mem_req}, 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vectors = 0; miscompares = 0;
        reset = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_outs", {28'd0, mem_req, rdata_valid, fault, mem_we}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;

        // LB 0x103: top lane 0x80 sign-extended
        access("lb", 1'b0, 3'b000, 32'h0000_0103, 32'h0, 2, 32'h80FF_FF12, 1'b0,
               32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
        @(negedge clk);
        chk("rdata_hold", rdata, 32'hFFFF_FF80);
        chk("valid_pulse", {31'd0, rdata_valid}, 32'd0);

        access("sh", 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b0,
               32'h0000_0020, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        access("sb", 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0, 1'b0,
               32'h0000_0010, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        access("lbu", 1'b0, 3'b100, 32'h0000_0001, 32'h0, 1, 32'h0000_8000, 1'b0,
               32'h0000_0000, 4'b0010, 32'h0, 32'h0000_0080);

        illegal("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 2'b01);
        illegal("sh_mis", 1'b1, 3'b001, 32'h0000_0001, 2'b01);
        illegal("f3_011", 1'b0, 3'b011, 32'h0000_0000, 2'b10);
        illegal("sbu", 1'b1, 3'b100, 32'h0000_0000, 2'b10);
        illegal("prio", 1'b1, 3'b011, 32'h0000_0003, 2'b10);

        // mem_ack while idle is ignored
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack", {30'd0, mem_req, rdata_valid}, 32'd0);

        // Timeout: mem_req high exactly 255 cycles, then fault code 11
        exp_q.push_back('{1'b1, 2'b11, 32'h0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0200;
        @(negedge clk);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mem_req) n++;
            else break;
        end
        chk("timeout_len", n, 32'd255);
        chk("timeout_err", {30'd0, fault, stall}, 32'd2);
        @(posedge clk); #1; req_valid = 1'b0;

        // An ack in the last allowed cycle is still honoured
        access("ack_edge", 1'b0, 3'b010, 32'h0000_0080, 32'h0, 255, 32'hCAFE_F00D, 1'b0,
               32'h0000_0080, 4'b1111, 32'h0, 32'hCAFE_F00D);

        // Reset in the middle of REQ clears everything at once
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_reset_outs", {27'd0, mem_req, stall, rdata_valid, fault, mem_we}, 32'd0);
        chk("mid_reset_addr", mem_addr, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access("lw_after_rst", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 3, 32'h1234_5678, 1'b1,
               32'h0000_0040, 4'b1111, 32'h0, 32'h1234_5678);

        // LHU then LH of the same halfword
        access("lhu", 1'b0, 3'b101, 32'h0000_0002, 32'h0, 1, 32'h8001_0000, 1'b0,
               32'h0000_0000, 4'b1100, 32'h0, 32'h0000_8001);
        access("lh", 1'b0, 3'b001, 32'h0000_0002, 32'h0, 1, 32'h8001_0000, 1'b0,
               32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8001);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
